// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM. Each instruction is walked through
// fetch, decode, execute, memory and writeback states, and the controls for
// the shared ALU and shared memory are decoded each cycle from the current
// state. Memory states honour a minimum latency and an optional ready
// handshake, so one controller covers both ideal and wait-stated memories.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   FETCH   | read instruction at PC, PC+4 through ALU; IR/PC load on done
//   DECODE  | opcode dispatch; ALU precomputes branch target PC+(imm<<2)
//   MEMADR  | effective address = rs + sign-extended immediate
//   MEMRD   | data read at ALUOut, held until the access completes
//   MEMWB   | loaded data written to rt
//   MEMWR   | data write at ALUOut, held until the access completes
//   EXEC    | R-type ALU operation selected by funct
//   RTYPEWB | R-type result written to rd
//   IEXEC   | I-type ALU operation with immediate operand
//   IWB     | I-type result written to rt
//   BRANCH  | compare and conditional PC load from ALUOut
//   JUMP    | unconditional PC load from jump target
module multicycle_control #(
  parameter int                  OP_SIZE       = 6,
  parameter int                  MEM_LATENCY   = 1,
  parameter int                  USE_MEM_READY = 0,
  parameter logic [OP_SIZE-1:0]  OP_RTYPE      = 'h00,
  parameter logic [OP_SIZE-1:0]  OP_LB         = 'h20,
  parameter logic [OP_SIZE-1:0]  OP_LH         = 'h21,
  parameter logic [OP_SIZE-1:0]  OP_SB         = 'h28,
  parameter logic [OP_SIZE-1:0]  OP_SH         = 'h29,
  parameter logic [OP_SIZE-1:0]  OP_BEQ        = 'h04,
  parameter logic [OP_SIZE-1:0]  OP_BGEZ       = 'h01,
  parameter logic [OP_SIZE-1:0]  OP_ADDI       = 'h08,
  parameter logic [OP_SIZE-1:0]  OP_ORI        = 'h0D,
  parameter logic [OP_SIZE-1:0]  OP_ANDI       = 'h0C,
  parameter logic [OP_SIZE-1:0]  OP_SLTI       = 'h0A,
  parameter logic [OP_SIZE-1:0]  OP_LUI        = 'h0F,
  parameter logic [OP_SIZE-1:0]  OP_J          = 'h02
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_SIZE-1:0] Opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               Branch,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal_op
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RTYPEWB = 4'd7,
    IEXEC   = 4'd8,
    IWB     = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam int             CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LATENCY - 1);

  state_t           state_q;
  state_t           next_state;
  state_t           decode_target;
  logic             decode_illegal;
  logic             is_store;
  logic             in_mem_state;
  logic             mem_done;
  logic [CNT_W-1:0] mem_cnt;

  // Access completes once the minimum latency has elapsed and, when the
  // handshake is enabled, the memory reports ready at that saturated count.
  assign in_mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign mem_done     = (mem_cnt == CNT_MAX) && (mem_ready || (USE_MEM_READY == 0));
  assign is_store     = (Opcode == OP_SB) || (Opcode == OP_SH);

  // Opcode dispatch target out of DECODE; unknown opcodes go straight back to FETCH.
  always_comb begin
    decode_target  = FETCH;
    decode_illegal = 1'b0;
    case (Opcode)
      OP_LB, OP_LH, OP_SB, OP_SH:                decode_target = MEMADR;
      OP_RTYPE:                                  decode_target = EXEC;
      OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_LUI: decode_target = IEXEC;
      OP_BEQ, OP_BGEZ:                           decode_target = BRANCH;
      OP_J:                                      decode_target = JUMP;
      default:                                   decode_illegal = 1'b1;
    endcase
  end

  // Next-state selection; memory states hold until their access completes.
  always_comb begin
    next_state = state_q;
    case (state_q)
      FETCH:   if (mem_done) next_state = DECODE;
      DECODE:  next_state = decode_target;
      MEMADR:  next_state = is_store ? MEMWR : MEMRD;
      MEMRD:   if (mem_done) next_state = MEMWB;
      MEMWB:   next_state = FETCH;
      MEMWR:   if (mem_done) next_state = FETCH;
      EXEC:    next_state = RTYPEWB;
      RTYPEWB: next_state = FETCH;
      IEXEC:   next_state = IWB;
      IWB:     next_state = FETCH;
      BRANCH:  next_state = FETCH;
      JUMP:    next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // State register and memory-access cycle counter (saturating, cleared on exit).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      mem_cnt <= '0;
    end else begin
      state_q <= next_state;
      if (in_mem_state && !mem_done) begin
        if (mem_cnt != CNT_MAX) mem_cnt <= mem_cnt + 1'b1;
      end else begin
        mem_cnt <= '0;
      end
    end
  end

  // Moore-style control decode; everything is held at zero while in reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    Branch      = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    state       = 4'd0;
    if (!reset) begin
      state = state_q;
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (mem_done) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          if (decode_illegal) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_done;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RTYPEWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
        end
        IWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          Branch      = 1'b1;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances (L=1; L=2; L=3 with ready
// handshake) share clock, reset and opcode. Expected per-cycle control
// vectors are queued per instruction and compared as the selected instance runs.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, br;
    logic [1:0] asb, aop, pcs;
    logic       done, ill;
  } ctl_t;

  typedef struct {
    ctl_t       exp;
    logic [5:0] op;
    logic       rdy;
  } sb_t;

  localparam logic [5:0] RTYPE = 6'h00, LB = 6'h20, LH = 6'h21, SB = 6'h28, SH = 6'h29;
  localparam logic [5:0] BEQ = 6'h04, BGEZ = 6'h01, ADDI = 6'h08, ORI = 6'h0D, ANDI = 6'h0C;
  localparam logic [5:0] SLTI = 6'h0A, LUI = 6'h0F, JMP = 6'h02, JUNK = 6'h3F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic [1:0] sel = 2'd0;
  ctl_t       obs [0:3];
  ctl_t       cur;
  sb_t        sb_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 3;
    localparam int R = (g == 2) ? 1 : 0;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, br, done, ill;
    logic [1:0] asb, aop, pcs;
    logic [3:0] st;
    multicycle_control #(.MEM_LATENCY(L), .USE_MEM_READY(R)) u_dut (
      .clk(clk), .reset(reset), .Opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
      .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(asa),
      .Branch(br), .ALUSrcB(asb), .ALUOp(aop), .PCSource(pcs), .state(st),
      .instr_done(done), .illegal_op(ill)
    );
    assign obs[g] = {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, br,
                     asb, aop, pcs, done, ill};
  end
  assign obs[3] = '0;

  always_comb cur = obs[sel];

  function automatic ctl_t st_only(input logic [3:0] s);
    ctl_t c;
    c = '0;
    c.st = s;
    return c;
  endfunction

  task automatic push(input ctl_t c, input logic [5:0] op, input logic rdy);
    sb_t e;
    e.exp = c;
    e.op  = op;
    e.rdy = rdy;
    sb_q.push_back(e);
  endtask

  // kind: 0 FETCH, 3 MEMRD, 5 MEMWR; stalls = cycles with ready low at saturation
  task automatic push_mem(input int kind, input int lat, input int stalls);
    ctl_t c;
    int   last;
    last = lat - 1 + stalls;
    for (int i = 0; i <= last; i++) begin
      c = st_only(4'(kind));
      if (kind == 0) begin
        c.mrd = 1'b1;
        c.asb = 2'b01;
        if (i == last) begin c.irw = 1'b1; c.pcw = 1'b1; end
      end else if (kind == 3) begin
        c.iord = 1'b1;
        c.mrd  = 1'b1;
      end else begin
        c.iord = 1'b1;
        c.mwr  = 1'b1;
        if (i == last) c.done = 1'b1;
      end
      push(c, JUNK, (stalls == 0) ? 1'b1 : (i == last));
    end
  endtask

  task automatic push_instr(input logic [5:0] op, input int lat, input int fstall, input int mstall);
    ctl_t c;
    logic legal;
    legal = op inside {RTYPE, LB, LH, SB, SH, BEQ, BGEZ, ADDI, ORI, ANDI, SLTI, LUI, JMP};
    push_mem(0, lat, fstall);
    c = st_only(4'd1); c.asb = 2'b11;
    if (!legal) begin c.ill = 1'b1; c.done = 1'b1; end
    push(c, op, 1'b1);
    if (op inside {LB, LH, SB, SH}) begin
      c = st_only(4'd2); c.asa = 1'b1; c.asb = 2'b10;
      push(c, op, 1'b1);
    end
    if (op inside {LB, LH}) begin
      push_mem(3, lat, mstall);
      c = st_only(4'd4); c.m2r = 1'b1; c.rw = 1'b1; c.done = 1'b1;
      push(c, JUNK, 1'b1);
    end else if (op inside {SB, SH}) begin
      push_mem(5, lat, mstall);
    end else if (op == RTYPE) begin
      c = st_only(4'd6); c.asa = 1'b1; c.aop = 2'b10; push(c, JUNK, 1'b1);
      c = st_only(4'd7); c.rdst = 1'b1; c.rw = 1'b1; c.done = 1'b1; push(c, JUNK, 1'b1);
    end else if (op inside {ADDI, ORI, ANDI, SLTI, LUI}) begin
      c = st_only(4'd8); c.asa = 1'b1; c.asb = 2'b10; c.aop = 2'b11; push(c, JUNK, 1'b1);
      c = st_only(4'd9); c.rw = 1'b1; c.done = 1'b1; push(c, JUNK, 1'b1);
    end else if (op inside {BEQ, BGEZ}) begin
      c = st_only(4'd10); c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01;
      c.br = 1'b1; c.done = 1'b1;
      push(c, JUNK, 1'b1);
    end else if (op == JMP) begin
      c = st_only(4'd11); c.pcw = 1'b1; c.pcs = 2'b10; c.done = 1'b1; push(c, JUNK, 1'b1);
    end
  endtask

  // Plays the queue one cycle per entry; returns the 1-based cycle of the first instr_done.
  task automatic run_q(input string name, output int done_at);
    sb_t e;
    int  cyc;
    cyc = 0;
    done_at = -1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      opcode    = e.op;
      mem_ready = e.rdy;
      #1;
      checks++;
      if (cur !== e.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc + 1, cur, e.exp);
      end
      if (cur.done === 1'b1 && done_at < 0) done_at = cyc + 1;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    opcode = JUNK;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (cur !== ctl_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", cur, ctl_t'(0));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [5:0] op, input int lat,
                         input int fstall, input int mstall, input int exp_lat);
    int d;
    push_instr(op, lat, fstall, mstall);
    run_q(name, d);
    checks++;
    if (d !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, d, exp_lat);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      do_reset();
    end
  endtask

  task automatic test_itype();
    sel = 2'd0;
    do_reset();
    run_one("addi_l1", ADDI, 1, 0, 0, 4);
    run_one("rtype_l1", RTYPE, 1, 0, 0, 4);
    sel = 2'd1;
    do_reset();
    run_one("ori_l2", ORI, 2, 0, 0, 5);
    run_one("andi_l2", ANDI, 2, 0, 0, 5);
    run_one("slti_l2", SLTI, 2, 0, 0, 5);
    run_one("lui_l2", LUI, 2, 0, 0, 5);
  endtask

  task automatic test_load_store();
    sel = 2'd1;
    do_reset();
    run_one("lb_l2", LB, 2, 0, 0, 7);
    run_one("lh_l2", LH, 2, 0, 0, 7);
    run_one("sb_l2", SB, 2, 0, 0, 6);
    sel = 2'd2;
    do_reset();
    run_one("sh_l3_ready", SH, 3, 0, 2, 10);
    run_one("lb_l3_ready", LB, 3, 1, 1, 11);
  endtask

  task automatic test_branch_jump();
    sel = 2'd0;
    do_reset();
    run_one("beq_l1", BEQ, 1, 0, 0, 3);
    run_one("j_l1", JMP, 1, 0, 0, 3);
    sel = 2'd1;
    do_reset();
    run_one("bgez_l2", BGEZ, 2, 0, 0, 4);
    run_one("j_l2", JMP, 2, 0, 0, 4);
  endtask

  task automatic test_illegal();
    sel = 2'd0;
    do_reset();
    run_one("illegal_3f", JUNK, 1, 0, 0, 2);
    run_one("after_illegal", ADDI, 1, 0, 0, 4);
  endtask

  task automatic test_back_to_back();
    int d;
    sel = 2'd1;
    do_reset();
    push_instr(SH, 2, 0, 0);
    push_instr(LB, 2, 0, 0);
    push_instr(RTYPE, 2, 0, 0);
    push_instr(BEQ, 2, 0, 0);
    push_instr(JUNK, 2, 0, 0);
    push_instr(JMP, 2, 0, 0);
    run_q("back_to_back", d);
  endtask

  task automatic test_reset_mid();
    ctl_t c;
    int   d;
    sel = 2'd2;
    do_reset();
    push_mem(0, 3, 0);
    c = st_only(4'd1); c.asb = 2'b11; push(c, LB, 1'b1);
    c = st_only(4'd2); c.asa = 1'b1; c.asb = 2'b10; push(c, LB, 1'b1);
    for (int i = 0; i < 2; i++) begin
      c = st_only(4'd3); c.iord = 1'b1; c.mrd = 1'b1; push(c, JUNK, 1'b1);
    end
    run_q("mid_prefix", d);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (cur !== ctl_t'(0)) begin
        errors++;
        $display("FAIL mid_reset_outputs %0d: got %h expected %h", i, cur, ctl_t'(0));
      end
      @(negedge clk);
    end
    reset = 1'b0;
    run_one("after_mid_reset", ADDI, 3, 0, 0, 6);
  endtask

  initial begin
    test_reset();
    test_itype();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main control decoder for the MIPS datapath.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives the shared-ALU/shared-memory datapath controls each cycle.
- Memory access states have a parametrised latency and an optional ready handshake, so the same block serves both ideal and wait-stated memories.

Parameters:
- OP_SIZE, 6, opcode width.
- MEM_LATENCY, 1, minimum cycles per memory access state (>=1).
- USE_MEM_READY, 0, 1 = memory states also wait for mem_ready.
- OP_RTYPE/OP_LB/OP_LH/OP_SB/OP_SH/OP_BEQ/OP_BGEZ/OP_ADDI/OP_ORI/OP_ANDI/OP_SLTI/OP_LUI/OP_J, 00/20/21/28/29/04/01/08/0D/0C/0A/0F/02 (hex), opcode encodings.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  OP_SIZE  from instruction register; valid from DECODE onward.
- mem_ready  in  1  memory access complete (ignored if USE_MEM_READY=0).
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Branch  out  1 each  datapath controls.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- ALUOp  out  2  00 add, 01 sub/compare, 10 funct, 11 I-type.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse in an instruction's final cycle.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RTYPEWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11. Remaining codes are unreachable and return to FETCH.
- Reset: on a clk edge with reset=1, state<=FETCH and mem_cnt<=0. While reset is high, all outputs are forced to 0, including state. A reset mid-instruction abandons that instruction with no pulses.
- Outputs are decoded combinationally from registered state, mem_cnt and mem_ready. Any output not listed for a state is 0.
- mem_cnt counts cycles inside FETCH, MEMRD and MEMWR and saturates at MEM_LATENCY-1.
  - done = (mem_cnt==MEM_LATENCY-1) && (mem_ready || !USE_MEM_READY).
  - mem_cnt clears when a state exits. While not done, the FSM holds state.
- Per-state outputs and transitions:
  - FETCH: MemRead=1, ALUSrcB=01. On done: IRWrite=1, PCWrite=1; next DECODE.
  - DECODE: ALUSrcB=11. Next by Opcode:
    - LB/LH/SB/SH -> MEMADR
    - RTYPE -> EXEC
    - ADDI/ORI/ANDI/SLTI/LUI -> IEXEC
    - BEQ/BGEZ -> BRANCH
    - J -> JUMP
    - otherwise -> FETCH with illegal_op=1 and instr_done=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10. Loads -> MEMRD; stores -> MEMWR.
  - MEMRD: IorD=1, MemRead=1. On done -> MEMWB.
  - MEMWB: MemtoReg=1, RegWrite=1, instr_done=1. Next FETCH.
  - MEMWR: IorD=1, MemWrite=1 (held for the whole access). On done: instr_done=1; next FETCH.
  - EXEC: ALUSrcA=1, ALUOp=10. Next RTYPEWB.
  - RTYPEWB: RegDst=1, RegWrite=1, instr_done=1. Next FETCH.
  - IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next IWB.
  - IWB: RegWrite=1, instr_done=1. Next FETCH.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, Branch=1, instr_done=1. Next FETCH.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1. Next FETCH.
- Latency with L=MEM_LATENCY and no ready stalls:
  - R/I-type: L+3 cycles.
  - Load: 2L+3 cycles.
  - Store: 2L+2 cycles.
  - Branch and jump: L+2 cycles.
  - Each cycle mem_ready is low at the saturated count adds 1 cycle.
- Opcode is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- If mem_ready is high before the count saturates, it has no effect; the minimum latency still applies.

Test Plan:
- Reset then ADDI, L=1, USE_MEM_READY=0:
  - state 0->1->8->9->0, IRWrite/PCWrite high in cycle 1, ALUOp=11 in IEXEC.
  - RegWrite=1 with RegDst=0 in IWB; instr_done high only in cycle 4.
- LB, L=2: FETCH 2 cycles (IRWrite only on 2nd), DECODE, MEMADR, MEMRD 2 cycles with IorD=1, MEMWB with MemtoReg=1; total 7 cycles.
- SH, L=3, USE_MEM_READY=1, mem_ready low until 2 cycles after count saturates:
  - MEMWR lasts 5 cycles with MemWrite held high; instr_done on the last cycle only.
- BEQ then J:
  - BRANCH gives PCWriteCond=1, PCSource=01, ALUOp=01.
  - JUMP gives PCWrite=1, PCSource=10; each is L+2 cycles.
- Opcode 6'h3F in DECODE: illegal_op and instr_done pulse for 1 cycle, next state FETCH, no RegWrite/MemWrite asserted.
- Reset asserted during MEMRD with L=3: all outputs 0 while reset is high; state 0 with mem_cnt 0 after release; the next FETCH takes the full 3 cycles.
